sobel_win3x3: RTL

- Neighbouring stage directly upstream of the Sobel gradient calculation.
- Takes the raster pixel byte stream from the UART receiver, one byte per valid pulse. Each frame is IMG_W x IMG_H bytes, row-major, and the stream has arbitrary gaps between bytes.
- Uses two line buffers and a 3x3 register window to build a new 3x3 neighbourhood for each interior pixel, then presents it to the gradient stage with a single-cycle valid.
- No image padding: border pixels produce no window.

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/sobel_win3x3_if.sv | 18 +
 rtl/sobel_line_buf.sv | 26 ++
 rtl/sobel_win3x3.sv | 108 ++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Constants and types shared by the Sobel window builder, the gradient stage and the display RAM.
package sobel_pkg;
    localparam int PIX_W     = 8;
    localparam int WIN_W     = 9 * PIX_W;
    localparam int IMG_W_DEF = 100;
    localparam int IMG_H_DEF = 100;

    // Bit offsets of each window pixel inside the packed 72-bit window
    localparam int WIN_TL = 64;
    localparam int WIN_TC = 56;
    localparam int WIN_TR = 48;
    localparam int WIN_ML = 40;
    localparam int WIN_MC = 32;
    localparam int WIN_MR = 24;
    localparam int WIN_BL = 16;
    localparam int WIN_BC = 8;
    localparam int WIN_BR = 0;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        pix_t top;
        pix_t mid;
        pix_t bot;
    } win_col_t;
endpackage

// File: rtl/sobel_win3x3_if.sv
// Pixel-in / window-out strobe bus between the UART receiver, the window builder and the gradient stage.
interface sobel_win3x3_if;
    logic [sobel_pkg::PIX_W-1:0] pi_data;
    logic                        pi_flag;
    logic [sobel_pkg::WIN_W-1:0] po_win;
    logic                        po_flag;
    logic                        po_frame_done;

    modport master (
        output pi_data, pi_flag,
        input  po_win, po_flag, po_frame_done
    );

    modport slave (
        input  pi_data, pi_flag,
        output po_win, po_flag, po_frame_done
    );
endinterface

// File: rtl/sobel_line_buf.sv
// One image row of pixels: single write port, combinational read at the same column address.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  pix_t          wr_data,
    output pix_t          rd_data
);

    // Contents are not reset; every entry is rewritten before it can reach an output.
    pix_t mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_win3x3.sv
// Builds a 3x3 neighbourhood for every interior pixel of a raster byte stream using two line buffers.
module sobel_win3x3
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CNT_W = 7
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    sobel_win3x3_if.slave  bus
);

    localparam int LB_AW = $clog2(IMG_W);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             col_last;
    logic             row_last;
    logic             interior;
    logic [LB_AW-1:0] lb_addr;
    pix_t             lb_a_rd;
    pix_t             lb_b_rd;
    win_col_t         col_new;
    win_col_t         col_l;
    win_col_t         col_c;
    win_col_t         col_r;
    logic             flag_q;
    logic             done_q;

    assign col_last = (col == CNT_W'(IMG_W - 1));
    assign row_last = (row == CNT_W'(IMG_H - 1));
    assign interior = (row >= CNT_W'(2)) && (col >= CNT_W'(2));
    assign lb_addr  = col[LB_AW-1:0];

    // lb_a holds the previous row, lb_b the one before; both read before the write lands
    sobel_line_buf #(.DEPTH(IMG_W), .AW(LB_AW)) lb_a (
        .sys_clk (sys_clk),
        .wr_en   (bus.pi_flag),
        .addr    (lb_addr),
        .wr_data (bus.pi_data),
        .rd_data (lb_a_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .AW(LB_AW)) lb_b (
        .sys_clk (sys_clk),
        .wr_en   (bus.pi_flag),
        .addr    (lb_addr),
        .wr_data (lb_a_rd),
        .rd_data (lb_b_rd)
    );

    assign col_new = '{top: lb_b_rd, mid: lb_a_rd, bot: bus.pi_data};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.pi_flag) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    // The shift runs across row boundaries; the stale columns it drags in are masked by interior
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_l <= '0;
            col_c <= '0;
            col_r <= '0;
        end else if (bus.pi_flag) begin
            col_l <= col_c;
            col_c <= col_r;
            col_r <= col_new;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            flag_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            flag_q <= bus.pi_flag && interior;
            done_q <= bus.pi_flag && row_last && col_last;
        end
    end

    assign bus.po_flag       = flag_q;
    assign bus.po_frame_done = done_q;

    always_comb begin
        bus.po_win                   = '0;
        bus.po_win[WIN_TL +: PIX_W]  = col_l.top;
        bus.po_win[WIN_TC +: PIX_W]  = col_c.top;
        bus.po_win[WIN_TR +: PIX_W]  = col_r.top;
        bus.po_win[WIN_ML +: PIX_W]  = col_l.mid;
        bus.po_win[WIN_MC +: PIX_W]  = col_c.mid;
        bus.po_win[WIN_MR +: PIX_W]  = col_r.mid;
        bus.po_win[WIN_BL +: PIX_W]  = col_l.bot;
        bus.po_win[WIN_BC +: PIX_W]  = col_c.bot;
        bus.po_win[WIN_BR +: PIX_W]  = col_r.bot;
    end

endmodule
